// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master drives operands and consumes results; the slave is the arithmetic unit.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: the carry chain is cut into CHUNK-bit slices, one register stage
// per slice, so a WIDTH-bit result emerges STAGES cycles after its operands are accepted.
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_add_sub_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign b_eff        = bus.sub ? ~bus.in2 : bus.in2;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added when a beat enters this stage.
    localparam int unsigned RemIn = WIDTH - k * CHUNK;
    localparam int unsigned ResW  = (k + 1) * CHUNK;

    logic              v_in;
    logic              c_in;
    logic [RemIn-1:0]  a_in;
    logic [RemIn-1:0]  b_in;
    logic [CHUNK:0]    slice;
    logic [ResW-1:0]   res_d;
    logic [ResW-1:0]   res_q;
    logic              valid_q;
    logic              carry_q;

    if (k == 0) begin : g_first
      assign v_in  = bus.in_valid;
      assign c_in  = bus.cin;
      assign a_in  = bus.in1;
      assign b_in  = b_eff;
      assign res_d = slice[CHUNK-1:0];
    end else begin : g_next
      assign v_in  = g_stage[k-1].valid_q;
      assign c_in  = g_stage[k-1].carry_q;
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign res_d = {slice[CHUNK-1:0], g_stage[k-1].res_q};
    end

    assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (!stall) begin
        valid_q <= v_in;
        carry_q <= slice[CHUNK];
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RemIn-CHUNK-1:0] a_q;
      logic [RemIn-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[RemIn-1:CHUNK];
          b_q <= b_in[RemIn-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= a_in[RemIn-1] ^ b_in[RemIn-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].res_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined add/subtract unit. Successor to the 4-bit ripple-carry adder.
- Splits a WIDTH-bit carry chain into CHUNK-bit slices and gives each slice its own register stage. Throughput is one operation per clock.
- Adds a per-transaction add/sub mode, a signed overflow flag and a valid/ready handshake with backpressure.
- Sits between the register-file read ports and the ALU result mux in the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per pipeline stage. WIDTH % CHUNK must be 0, otherwise elaboration fails.
- STAGES, WIDTH/CHUNK, derived (localparam). This is the pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry/borrow-in
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out (for subtraction: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Arithmetic: the effective operand is b = sub ? ~in2 : in2.
  - Result is {cout, sum} = in1 + b + cin, computed modulo 2^WIDTH with the carry kept.
  - Plain subtraction uses sub=1, cin=1.
  - ovf = carry into bit WIDTH-1 XOR cout.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) holds a valid bit, the result slices [0 .. (k+1)*CHUNK-1] computed so far, the inter-stage carry, and the not-yet-added upper slices of in1 and b.
  - Stage k adds slice k using the carry from stage k-1; stage 0 uses cin.
  - ovf and cout are formed in the last stage.
- Latency:
  - A beat is accepted at a clock edge when in_valid && in_ready.
  - The result appears on sum/cout/ovf with out_valid=1 after STAGES edges, counting the accepting edge. With the defaults, a beat accepted at edge 1 is visible after edge 4.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational, with no in_valid→in_ready path.
  - While stalled, every stage register holds, and sum/cout/ovf/out_valid stay stable.
  - When not stalled, all stages advance each edge. Stage 0 loads the incoming beat, or a bubble (valid=0) if no beat is accepted.
  - The result transfers on the edge where out_valid && out_ready.
  - Bubbles are not compressed. Order is strictly preserved. No beat is dropped or duplicated.
- Simultaneous events: the final stage may hand off its result and receive a new one on the same edge, so full-rate streaming with out_ready=1 has no gaps.
- Reset:
  - rst_n low clears all stage valid bits and data registers immediately, without waiting for a clock edge.
  - Outputs during reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Asserting reset mid-operation discards all in-flight beats.
  - After rst_n deasserts, the first edge may accept a beat.
- Outputs are registered only; there is no combinational path from in1/in2 to sum.
- sum/cout/ovf are don't-care when out_valid=0, but must be 0 immediately after reset.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. Full-chain carry: add 0xFFFF+0x0001, cin=0 → after 4 edges sum=0x0000, cout=1, ovf=0.
2. Signed overflow on add: add 0x7FFF+0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also add 0x1234+0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
3. Subtraction, sub=1, cin=1:
   - 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0.
   - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
4. Streaming: one beat every cycle for 8 cycles, alternating sub, with out_ready=1 → 8 consecutive out_valid cycles, results in order, each matching a reference model.
5. Backpressure: with the pipeline full, hold out_ready=0 for 3 cycles → in_ready=0, sum/out_valid frozen. On release, all results are delivered once, in order.
6. Reset mid-flight: pull rst_n low with 3 beats in flight → out_valid=0 and sum=0 without waiting for a clock edge. After release, no stale result ever appears, and a new beat completes with latency 4.
